// File: rtl/map_bus_mux_if.sv
// map_bus_mux_if: groups the per-channel mapper buses and the shared CPU/ROM/BSRAM buses.
// Latency: none; this is a bundle of wires.
// Backpressure: none; ownership of the shared bus is decided by map_bus_mux.
// Ports: ch_* are per-channel mapper outputs packed NCH wide (channel k at slice k);
//        di/irq_n/rom_*/bsram_* are the shared bus driven by the arbiter.
//        master = mapper/board side, slave = arbiter side.
interface map_bus_mux_if #(
    parameter int NCH    = 5,
    parameter int ROM_AW = 24,
    parameter int RAM_AW = 20
);
    logic [NCH-1:0]        ch_active;
    logic [NCH*8-1:0]      ch_do;
    logic [NCH-1:0]        ch_irq_n;
    logic [NCH*ROM_AW-1:0] ch_rom_addr;
    logic [NCH-1:0]        ch_rom_ce_n;
    logic [NCH-1:0]        ch_rom_oe_n;
    logic [NCH-1:0]        ch_rom_word;
    logic [NCH*RAM_AW-1:0] ch_bsram_addr;
    logic [NCH*8-1:0]      ch_bsram_d;
    logic [NCH-1:0]        ch_bsram_ce_n;
    logic [NCH-1:0]        ch_bsram_oe_n;
    logic [NCH-1:0]        ch_bsram_we_n;

    logic [7:0]            di;
    logic                  irq_n;
    logic [ROM_AW-1:0]     rom_addr;
    logic                  rom_ce_n;
    logic                  rom_oe_n;
    logic                  rom_word;
    logic [RAM_AW-1:0]     bsram_addr;
    logic [7:0]            bsram_d;
    logic                  bsram_ce_n;
    logic                  bsram_oe_n;
    logic                  bsram_we_n;

    modport master (
        output ch_active, ch_do, ch_irq_n, ch_rom_addr, ch_rom_ce_n, ch_rom_oe_n, ch_rom_word,
               ch_bsram_addr, ch_bsram_d, ch_bsram_ce_n, ch_bsram_oe_n, ch_bsram_we_n,
        input  di, irq_n, rom_addr, rom_ce_n, rom_oe_n, rom_word,
               bsram_addr, bsram_d, bsram_ce_n, bsram_oe_n, bsram_we_n
    );

    modport slave (
        input  ch_active, ch_do, ch_irq_n, ch_rom_addr, ch_rom_ce_n, ch_rom_oe_n, ch_rom_word,
               ch_bsram_addr, ch_bsram_d, ch_bsram_ce_n, ch_bsram_oe_n, ch_bsram_we_n,
        output di, irq_n, rom_addr, rom_ce_n, rom_oe_n, rom_word,
               bsram_addr, bsram_d, bsram_ce_n, bsram_oe_n, bsram_we_n
    );
endinterface

// File: rtl/map_bus_mux.sv
// map_bus_mux: registered owner select of the cartridge bus among NCH mapper channels.
// Latency: bus data/controls 0 cycles from the owner; an owner change takes >= 1+GUARD cycles from an idle CPU boundary.
// Backpressure: none; a pending switch waits in DRAIN until the owner is idle on a sysclkf_ce strobe.
// Ports: mclk/rst_n clock and async active-low reset; sysclkf_ce CPU cycle-boundary strobe;
//        conflict_clr clears the sticky conflict flag; bus (slave) carries channel buses in and the
//        shared bus out; sel/switching/conflict/turbo_allow report arbiter status.
module map_bus_mux #(
    parameter int             NCH         = 5,
    parameter int             ROM_AW      = 24,
    parameter int             RAM_AW      = 20,
    parameter int             DEFAULT_CH  = 0,
    parameter int             GUARD       = 4,
    parameter logic [NCH-1:0] TURBO_BLOCK = 5'b01010
) (
    input  logic         mclk,
    input  logic         rst_n,
    input  logic         sysclkf_ce,
    input  logic         conflict_clr,
    map_bus_mux_if.slave bus,
    output logic [2:0]   sel,
    output logic         switching,
    output logic         conflict,
    output logic         turbo_allow
);
    typedef enum logic [1:0] {ST_LOCKED = 2'd0, ST_DRAIN = 2'd1, ST_GUARD = 2'd2} state_t;

    localparam logic [3:0] GUARD_RELOAD = (GUARD > 0) ? 4'(GUARD - 1) : 4'd0;

    state_t            r_state, w_state_nxt;
    logic [2:0]        r_sel, w_sel_nxt, r_tgt, w_tgt_nxt, w_req;
    logic [3:0]        r_cnt, w_cnt_nxt, w_nact;
    logic              r_conflict, w_multi, w_idle;
    logic              w_unused_act0;

    // Fields of the currently selected channel.
    logic [7:0]        w_s_do, w_s_bsram_d;
    logic [ROM_AW-1:0] w_s_rom_addr;
    logic [RAM_AW-1:0] w_s_bsram_addr;
    logic              w_s_irq_n, w_s_rom_ce_n, w_s_rom_oe_n, w_s_rom_word;
    logic              w_s_bsram_ce_n, w_s_bsram_oe_n, w_s_bsram_we_n, w_s_turbo_blk;

    // Channel 0 is the fallback owner; its active bit carries no request.
    assign w_unused_act0 = bus.ch_active[0];

    // Lowest active coprocessor channel wins; count requesters for conflict detection.
    always_comb begin
        w_req  = 3'(DEFAULT_CH);
        w_nact = 4'd0;
        for (int k = NCH - 1; k >= 1; k--) begin
            if (bus.ch_active[k]) begin
                w_req  = 3'(k);
                w_nact = w_nact + 4'd1;
            end
        end
    end
    assign w_multi = (w_nact >= 4'd2);

    always_comb begin
        w_s_do         = '0;
        w_s_irq_n      = 1'b1;
        w_s_rom_addr   = '0;
        w_s_rom_ce_n   = 1'b1;
        w_s_rom_oe_n   = 1'b1;
        w_s_rom_word   = 1'b0;
        w_s_bsram_addr = '0;
        w_s_bsram_d    = '0;
        w_s_bsram_ce_n = 1'b1;
        w_s_bsram_oe_n = 1'b1;
        w_s_bsram_we_n = 1'b1;
        w_s_turbo_blk  = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (r_sel == 3'(k)) begin
                w_s_do         = bus.ch_do[8*k +: 8];
                w_s_irq_n      = bus.ch_irq_n[k];
                w_s_rom_addr   = bus.ch_rom_addr[ROM_AW*k +: ROM_AW];
                w_s_rom_ce_n   = bus.ch_rom_ce_n[k];
                w_s_rom_oe_n   = bus.ch_rom_oe_n[k];
                w_s_rom_word   = bus.ch_rom_word[k];
                w_s_bsram_addr = bus.ch_bsram_addr[RAM_AW*k +: RAM_AW];
                w_s_bsram_d    = bus.ch_bsram_d[8*k +: 8];
                w_s_bsram_ce_n = bus.ch_bsram_ce_n[k];
                w_s_bsram_oe_n = bus.ch_bsram_oe_n[k];
                w_s_bsram_we_n = bus.ch_bsram_we_n[k];
                w_s_turbo_blk  = TURBO_BLOCK[k];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_tgt_nxt   = r_tgt;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_LOCKED: begin
                if (w_req != r_sel) begin
                    w_state_nxt = ST_DRAIN;
                    w_tgt_nxt   = w_req;
                end
            end
            ST_DRAIN: begin
                if (w_req == r_sel) begin
                    // Request withdrawn before the bus went quiet: nothing to hand over.
                    w_state_nxt = ST_LOCKED;
                end else begin
                    w_tgt_nxt = w_req;
                    if (sysclkf_ce && w_s_rom_ce_n && w_s_bsram_ce_n) begin
                        if (GUARD > 0) begin
                            w_state_nxt = ST_GUARD;
                            w_cnt_nxt   = GUARD_RELOAD;
                        end else begin
                            w_sel_nxt   = w_req;
                            w_state_nxt = ST_LOCKED;
                        end
                    end
                end
            end
            ST_GUARD: begin
                // A new target restarts the full quiet window.
                if (w_req != r_tgt) begin
                    w_tgt_nxt = w_req;
                    w_cnt_nxt = GUARD_RELOAD;
                end else if (r_cnt == 4'd0) begin
                    w_sel_nxt   = r_tgt;
                    w_state_nxt = ST_LOCKED;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: w_state_nxt = ST_LOCKED;
        endcase
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_LOCKED;
            r_sel      <= 3'(DEFAULT_CH);
            r_tgt      <= 3'(DEFAULT_CH);
            r_cnt      <= 4'd0;
            r_conflict <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_tgt   <= w_tgt_nxt;
            r_cnt   <= w_cnt_nxt;
            // Set has priority over clear so an ongoing conflict cannot be hidden.
            if (w_multi)
                r_conflict <= 1'b1;
            else if (conflict_clr)
                r_conflict <= 1'b0;
        end
    end

    assign w_idle = !rst_n || (r_state == ST_GUARD);

    always_comb begin
        bus.di         = w_idle ? 8'd0 : w_s_do;
        bus.irq_n      = w_idle ? 1'b1 : w_s_irq_n;
        bus.rom_addr   = w_idle ? '0   : w_s_rom_addr;
        bus.rom_ce_n   = w_idle ? 1'b1 : w_s_rom_ce_n;
        bus.rom_oe_n   = w_idle ? 1'b1 : w_s_rom_oe_n;
        bus.rom_word   = w_idle ? 1'b0 : w_s_rom_word;
        bus.bsram_addr = w_idle ? '0   : w_s_bsram_addr;
        bus.bsram_d    = w_idle ? 8'd0 : w_s_bsram_d;
        bus.bsram_ce_n = w_idle ? 1'b1 : w_s_bsram_ce_n;
        bus.bsram_oe_n = w_idle ? 1'b1 : w_s_bsram_oe_n;
        bus.bsram_we_n = w_idle ? 1'b1 : w_s_bsram_we_n;
    end

    assign sel         = r_sel;
    assign switching   = (r_state != ST_LOCKED);
    assign conflict    = r_conflict;
    assign turbo_allow = ~w_s_turbo_blk & ~switching;
endmodule
